mc_main_control: RTL and testbench
==================================

// Module: mc_main_control
// PURPOSE
// - Multi-cycle MIPS main controller: a Moore FSM that sequences each instruction through fetch/decode/execute/mem/writeback.
// - Drives the datapath muxes and enables, and issues alu_op to the ALU-control decoder.
// - Consumes the decoder's undefined-funct flag and traps illegal instructions.
// - Sits between instruction register opcode, unified instr/data memory (req/ready handshake) and multi-cycle datapath.
// PARAMETERS
// - CNT_W        32  width of retired-instruction counter
// - MEM_WAIT_EN  1   1: honour mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
// - clk            in   1      single clock, all state on rising edge
// - rst            in   1      synchronous, active-high reset
// - opcode         in   6      instr[31:26] from instruction register
// - zero           in   1      ALU zero flag
// - alu_undefined  in   1      undefined_instr from ALU-control decoder
// - mem_ready      in   1      memory completes current access this cycle
// - mem_req        out  1      memory access request
// - mem_write      out  1      write strobe, valid with mem_req
// - iord           out  1      0: addr=PC, 1: addr=ALUOut
// - ir_write       out  1      load instruction register
// - pc_en          out  1      pc_write | (branch & zero)
// - pc_src         out  2      00 ALUResult, 01 ALUOut, 10 jump target
// - reg_write      out  1      register-file write enable
// - reg_dst        out  1      0 rt, 1 rd
// - mem_to_reg     out  1      0 ALUOut, 1 data reg
// - alu_src_a      out  1      0 PC, 1 A
// - alu_src_b      out  2      00 B, 01 const 4, 10 signimm, 11 signimm<<2
// - alu_op         out  2      00 add (lw/sw/addi/PC), 01 sub (beq), 10 R-type funct
// - undefined_instr out 1      sticky illegal-instruction trap
// - instr_retired  out  CNT_W  count of completed instructions
// - state_dbg      out  4      current state encoding
// BEHAVIOUR
// - Outputs decode combinationally from state register only (Moore); mem_ready/zero gate enables only as stated.
// - Non-listed outputs are 0 in every state.
// - State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 12.
// - Reset: state=FETCH, instr_retired=0, trap=0; outputs are FETCH decode.
// - FETCH: mem_req=1, iord=0, alu_src_b=01, alu_op=00.
//   - ir_write=pc_write=mem_ready; stay until mem_ready, then DECODE.
// - DECODE: alu_src_b=11, alu_op=00; next state by opcode:
//   - 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP
//   - any other -> ILLEGAL
// - MEMADR: alu_src_a=1, alu_src_b=10; lw -> MEMRD, sw -> MEMWR (opcode held stable by IR).
// - MEMRD: mem_req=1, iord=1; wait for mem_ready -> MEMWB.
// - MEMWB: reg_write=1, mem_to_reg=1 -> FETCH.
// - MEMWR: mem_req=1, mem_write=1, iord=1; held until mem_ready -> FETCH.
// - EXECUTE: alu_src_a=1, alu_op=10; alu_undefined=1 -> ILLEGAL (no writeback), else ALUWB.
// - ALUWB: reg_write=1, reg_dst=1 -> FETCH.
// - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero -> FETCH.
// - ADDIEX: alu_src_a=1, alu_src_b=10 -> ADDIWB.
// - ADDIWB: reg_write=1 -> FETCH.
// - JUMP: pc_src=10, pc_en=1 -> FETCH.
// - ILLEGAL: all enables 0, undefined_instr=1, self-loop until rst.
// - instr_retired: +1 on every transition into FETCH from a non-FETCH state; wraps modulo 2^CNT_W.
//   - No count on ILLEGAL entry or from reset.
// - Latency in cycles, mem_ready=1:
//   - lw 5, sw 4, R 4, addi 4, beq 3, j 3
//   - each wait cycle adds one
// - rst in any state, incl. mid memory wait: next cycle FETCH, mem_req reasserted, counter cleared.
// STRUCTURE
// - mips_pkg: opcode constants, ALU_OP_* encodings, state_t enum (4-bit).
//   - Shared with ALU-control decoder and datapath.
// - Single module; next-state logic and output decode as two always_comb blocks, one always_ff for state/counter/trap.
// - No sub-module.
// TESTING
// - lw, mem_ready=1: states 0,1,2,3,4,0; reg_write+mem_to_reg in cycle 5; instr_retired 0->1.
// - sw with mem_ready low 3 cycles in MEMWR: mem_write held 4 cycles, then FETCH; reg_write never 1.
// - beq zero=1: pc_en=1,pc_src=01,alu_op=01 in BRANCH; with zero=0 -> pc_en=0; both retire.
// - R-type funct illegal (alu_undefined=1 in EXECUTE): ILLEGAL, undefined_instr=1, reg_write 0, counter unchanged.
// - opcode 111111 in DECODE -> ILLEGAL next cycle; rst -> FETCH, undefined_instr=0, instr_retired=0.
// - rst asserted in MEMRD waiting: next cycle state_dbg=0, mem_req=1, iord=0.

Source files
------------

// File: rtl/mc_main_control_pkg.sv
// mc_main_control_pkg: opcodes, ALU operation encodings and controller state type
// shared by the main controller, the ALU-control decoder and the datapath.
package mc_main_control_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;
endpackage

// File: rtl/mc_main_control_if.sv
// mc_main_control_if: controller <-> IR/memory/datapath signal bundle;
// master is the controller, slave is the datapath/memory side.
interface mc_main_control_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             zero;
    logic             alu_undefined;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             undefined_instr;
    logic [CNT_W-1:0] instr_retired;
    logic [3:0]       state_dbg;
    modport master (
        input  opcode, zero, alu_undefined, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, undefined_instr, instr_retired, state_dbg
    );
    modport slave (
        output opcode, zero, alu_undefined, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, undefined_instr, instr_retired, state_dbg
    );
endinterface

// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS Moore controller sequencing fetch/decode/execute/mem/writeback,
// with a sticky illegal-instruction trap and a retired-instruction counter.
module mc_main_control
    import mc_main_control_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mc_main_control_if.master  bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic             r_trap;
    logic             w_rdy;
    assign w_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                                (bus.opcode == OP_RTYPE) ? S_EXECUTE :
                                (bus.opcode == OP_BEQ)   ? S_BRANCH  :
                                (bus.opcode == OP_ADDI)  ? S_ADDIEX  :
                                (bus.opcode == OP_J)     ? S_JUMP    : S_ILLEGAL;
            S_MEMADR:  w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = bus.alu_undefined ? S_ILLEGAL : S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ILLEGAL: w_next = S_ILLEGAL;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_src     = 2'b00;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = ALU_OP_ADD;
        case (r_state)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = w_rdy;
                bus.pc_en     = w_rdy;
            end
            S_DECODE:  bus.alu_src_b = 2'b11;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_SUB;
                bus.pc_src    = 2'b01;
                bus.pc_en     = bus.zero;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_ADDIWB:  bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end
    // An instruction retires on each return to FETCH; ILLEGAL never returns, so it never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_trap    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_retired <= (w_next == S_FETCH && r_state != S_FETCH) ? r_retired + CNT_W'(1) : r_retired;
            r_trap    <= r_trap | (w_next == S_ILLEGAL);
        end
    end
    assign bus.undefined_instr = r_trap;
    assign bus.instr_retired   = r_retired;
    assign bus.state_dbg       = r_state;
endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control: directed instruction sequences through the multi-cycle controller,
// checking state, control outputs, trap and retire count with immediate assertions.
module tb_mc_main_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    mc_main_control_if #(.CNT_W(32)) bus ();
    mc_main_control #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        bus.opcode = 6'b000000;
        bus.zero = 1'b0;
        bus.alu_undefined = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", 32'(bus.state_dbg), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 1);
        chk("rst_alu_src_b", 32'(bus.alu_src_b), 1);
        chk("rst_ir_write", 32'(bus.ir_write), 1);
        chk("rst_retired", bus.instr_retired, 0);
        chk("rst_trap", 32'(bus.undefined_instr), 0);
        // lw with mem_ready=1: 0,1,2,3,4,0
        bus.opcode = 6'b100011;
        tick(); chk("lw_decode", 32'(bus.state_dbg), 1);
        chk("lw_decode_srcb", 32'(bus.alu_src_b), 3);
        tick(); chk("lw_memadr", 32'(bus.state_dbg), 2);
        chk("lw_memadr_srca", 32'(bus.alu_src_a), 1);
        chk("lw_memadr_srcb", 32'(bus.alu_src_b), 2);
        tick(); chk("lw_memrd", 32'(bus.state_dbg), 3);
        chk("lw_memrd_iord", 32'({bus.mem_req, bus.iord}), 3);
        tick(); chk("lw_memwb", 32'(bus.state_dbg), 4);
        chk("lw_memwb_wr", 32'({bus.reg_write, bus.mem_to_reg}), 3);
        chk("lw_memwb_cnt", bus.instr_retired, 0);
        tick(); chk("lw_fetch", 32'(bus.state_dbg), 0);
        chk("lw_retired", bus.instr_retired, 1);
        // sw with mem_ready low for 3 cycles in MEMWR
        bus.opcode = 6'b101011;
        tick(); tick();
        chk("sw_memadr", 32'(bus.state_dbg), 2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_memwr_wait", 32'({bus.state_dbg, bus.mem_write, bus.mem_req, bus.iord, bus.reg_write}), 32'h5e);
        end
        bus.mem_ready = 1'b1;
        #1 chk("sw_memwr_last", 32'({bus.state_dbg, bus.mem_write, bus.reg_write}), 32'h16);
        tick(); chk("sw_fetch", 32'(bus.state_dbg), 0);
        chk("sw_retired", bus.instr_retired, 2);
        // FETCH stall: no IR/PC load while memory not ready
        bus.mem_ready = 1'b0;
        #1 chk("fetch_stall_en", 32'({bus.ir_write, bus.pc_en, bus.mem_req}), 1);
        tick(); chk("fetch_stall_state", 32'(bus.state_dbg), 0);
        bus.mem_ready = 1'b1;
        // beq taken then not taken
        bus.opcode = 6'b000100;
        bus.zero = 1'b1;
        tick(); tick();
        chk("beq_state", 32'(bus.state_dbg), 8);
        chk("beq_taken", 32'({bus.pc_en, bus.pc_src, bus.alu_op, bus.alu_src_a}), 32'b1_01_01_1);
        bus.zero = 1'b0;
        #1 chk("beq_zero0_pc_en", 32'(bus.pc_en), 0);
        tick(); chk("beq_retired", bus.instr_retired, 3);
        tick(); tick();
        chk("beq2_pc_en", 32'({bus.state_dbg, bus.pc_en}), 32'h10);
        tick(); chk("beq2_retired", bus.instr_retired, 4);
        // jump
        bus.opcode = 6'b000010;
        tick(); tick();
        chk("j_state", 32'(bus.state_dbg), 11);
        chk("j_ctrl", 32'({bus.pc_src, bus.pc_en, bus.reg_write}), 32'b10_1_0);
        tick(); chk("j_retired", 32'({bus.state_dbg, bus.instr_retired[7:0]}), 32'h005);
        // addi
        bus.opcode = 6'b001000;
        tick(); tick();
        chk("addi_ex", 32'({bus.state_dbg, bus.alu_src_a, bus.alu_src_b}), 32'b1001_1_10);
        tick(); chk("addi_wb", 32'({bus.state_dbg, bus.reg_write, bus.reg_dst}), 32'b1010_1_0);
        tick(); chk("addi_retired", bus.instr_retired, 6);
        // R-type legal
        bus.opcode = 6'b000000;
        tick(); tick();
        chk("r_exec", 32'({bus.state_dbg, bus.alu_src_a, bus.alu_op, bus.alu_src_b}), 32'b0110_1_10_00);
        tick(); chk("r_wb", 32'({bus.state_dbg, bus.reg_write, bus.reg_dst}), 32'b0111_1_1);
        tick(); chk("r_retired", bus.instr_retired, 7);
        // reset while MEMRD waits for memory
        bus.opcode = 6'b100011;
        tick(); tick();
        bus.mem_ready = 1'b0;
        tick(); chk("rstrd_memrd", 32'(bus.state_dbg), 3);
        tick(); chk("rstrd_hold", 32'(bus.state_dbg), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        chk("rstrd_fetch", 32'({bus.state_dbg, bus.mem_req, bus.iord}), 32'b0000_1_0);
        chk("rstrd_cnt", bus.instr_retired, 0);
        // one addi, then an R-type with an undefined funct
        bus.opcode = 6'b001000;
        tick(); tick(); tick(); tick();
        chk("addi2_retired", bus.instr_retired, 1);
        bus.opcode = 6'b000000;
        bus.alu_undefined = 1'b1;
        tick(); tick();
        chk("rill_exec", 32'(bus.state_dbg), 6);
        tick();
        chk("rill_state", 32'(bus.state_dbg), 12);
        chk("rill_trap", 32'({bus.undefined_instr, bus.reg_write, bus.mem_req, bus.pc_en}), 32'b1000);
        chk("rill_cnt", bus.instr_retired, 1);
        bus.alu_undefined = 1'b0;
        tick(); chk("rill_stuck", 32'({bus.state_dbg, bus.undefined_instr}), 32'b1100_1);
        chk("rill_cnt2", bus.instr_retired, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rill_rst", 32'({bus.state_dbg, bus.undefined_instr}), 0);
        chk("rill_rst_cnt", bus.instr_retired, 0);
        // undefined opcode straight from DECODE
        bus.opcode = 6'b111111;
        tick(); chk("bad_decode", 32'(bus.state_dbg), 1);
        tick(); chk("bad_illegal", 32'({bus.state_dbg, bus.undefined_instr}), 32'b1100_1);
        chk("bad_cnt", bus.instr_retired, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("bad_rst", 32'({bus.state_dbg, bus.undefined_instr, bus.mem_req}), 32'b0000_0_1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
